// File: rtl/cajero_atm_ctrl.sv
// ATM controller: card session FSM with 4-digit PIN entry, attempt
// counting with warning/lockout, and deposit/withdrawal on a held balance.
module cajero_atm_ctrl #(
  parameter int               BAL_W        = 64,
  parameter logic [BAL_W-1:0] BALANCE_INIT = 64'd10000,
  parameter int               MAX_INTENTOS = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             TARGETA_RECIBIDA,
  input  logic [15:0]      PIN,
  input  logic [3:0]       DIGITO,
  input  logic             DIGITO_STB,
  input  logic             TIPO_TRANS,
  input  logic [31:0]      MONTO,
  input  logic             MONTO_STB,
  output logic [BAL_W-1:0] BALANCE,
  output logic             BALANCE_ACTUALIZADO,
  output logic             ENTREGAR_DINERO,
  output logic             PIN_INCORRECTO,
  output logic             ADVERTENCIA,
  output logic             BLOQUEO,
  output logic             FONDOS_INSUFICIENTES
);

  localparam int CNT_W = $clog2(MAX_INTENTOS + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INTENTOS);
  localparam logic [CNT_W-1:0] ADV_CNT = CNT_W'(MAX_INTENTOS - 1);

  localparam logic [2:0] ST_ESPERA_TARJETA = 3'd0;
  localparam logic [2:0] ST_RECIBE_PIN     = 3'd1;
  localparam logic [2:0] ST_VERIFICA_PIN   = 3'd2;
  localparam logic [2:0] ST_ESPERA_MONTO   = 3'd3;
  localparam logic [2:0] ST_PROCESA        = 3'd4;
  localparam logic [2:0] ST_BLOQUEO        = 3'd5;

  logic [2:0]       state_r, state_s;
  logic [CNT_W-1:0] intentos_r, intentos_s, intentos_inc_s;
  logic [2:0]       digit_cnt_r, digit_cnt_s;
  logic [15:0]      shift_r, shift_s;
  logic             digito_prev_r, monto_prev_r;
  logic             digito_ev_s, monto_ev_s;
  logic [31:0]      monto_r, monto_s;
  logic             tipo_r, tipo_s;
  logic [BAL_W-1:0] balance_r, balance_s, monto_ext_s;
  logic [BAL_W:0]   sum_s;
  logic             bal_act_r, bal_act_s;
  logic             entregar_r, entregar_s;
  logic             pin_inc_r, pin_inc_s;
  logic             fondos_r, fondos_s;
  logic             adv_r, adv_s;
  logic             bloq_r, bloq_s;

  // A strobe counts once, on its rising edge; the carry bit flags deposit overflow.
  assign digito_ev_s    = DIGITO_STB & ~digito_prev_r;
  assign monto_ev_s     = MONTO_STB & ~monto_prev_r;
  assign intentos_inc_s = intentos_r + CNT_W'(1);
  assign monto_ext_s    = BAL_W'(monto_r);
  assign sum_s          = {1'b0, balance_r} + {1'b0, monto_ext_s};

  // Next-state, datapath and next-output computation for the session FSM.
  always_comb begin
    state_s     = state_r;
    intentos_s  = intentos_r;
    digit_cnt_s = digit_cnt_r;
    shift_s     = shift_r;
    monto_s     = monto_r;
    tipo_s      = tipo_r;
    balance_s   = balance_r;
    bal_act_s   = 1'b0;
    entregar_s  = 1'b0;
    pin_inc_s   = 1'b0;
    fondos_s    = 1'b0;
    case (state_r)
      ST_ESPERA_TARJETA: begin
        if (TARGETA_RECIBIDA) begin
          state_s     = ST_RECIBE_PIN;
          digit_cnt_s = 3'd0;
          shift_s     = 16'd0;
        end else begin
          state_s = ST_ESPERA_TARJETA;
        end
      end
      ST_RECIBE_PIN: begin
        // Card removal wins over a coincident digit strobe.
        if (!TARGETA_RECIBIDA) begin
          state_s     = ST_ESPERA_TARJETA;
          digit_cnt_s = 3'd0;
          shift_s     = 16'd0;
        end else if (digito_ev_s) begin
          shift_s     = {shift_r[11:0], DIGITO};
          digit_cnt_s = digit_cnt_r + 3'd1;
          if (digit_cnt_r == 3'd3) begin
            state_s = ST_VERIFICA_PIN;
          end else begin
            state_s = ST_RECIBE_PIN;
          end
        end else begin
          state_s = ST_RECIBE_PIN;
        end
      end
      ST_VERIFICA_PIN: begin
        if (shift_r == PIN) begin
          intentos_s = {CNT_W{1'b0}};
          state_s    = ST_ESPERA_MONTO;
        end else begin
          intentos_s = intentos_inc_s;
          pin_inc_s  = 1'b1;
          if (intentos_inc_s == MAX_CNT) begin
            state_s = ST_BLOQUEO;
          end else begin
            state_s = ST_ESPERA_TARJETA;
          end
        end
      end
      ST_ESPERA_MONTO: begin
        if (!TARGETA_RECIBIDA) begin
          state_s = ST_ESPERA_TARJETA;
        end else if (monto_ev_s) begin
          monto_s = MONTO;
          tipo_s  = TIPO_TRANS;
          state_s = ST_PROCESA;
        end else begin
          state_s = ST_ESPERA_MONTO;
        end
      end
      ST_PROCESA: begin
        state_s = ST_ESPERA_TARJETA;
        if (!tipo_r) begin
          bal_act_s = 1'b1;
          if (sum_s[BAL_W]) begin
            balance_s = {BAL_W{1'b1}};
          end else begin
            balance_s = sum_s[BAL_W-1:0];
          end
        end else if (monto_ext_s <= balance_r) begin
          balance_s  = balance_r - monto_ext_s;
          bal_act_s  = 1'b1;
          entregar_s = 1'b1;
        end else begin
          fondos_s = 1'b1;
        end
      end
      ST_BLOQUEO: begin
        state_s = ST_BLOQUEO;
      end
      default: begin
        state_s = ST_ESPERA_TARJETA;
      end
    endcase
    adv_s  = (intentos_s == ADV_CNT) && (state_s != ST_BLOQUEO);
    bloq_s = (state_s == ST_BLOQUEO);
  end

  // State, datapath and registered outputs with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r       <= ST_ESPERA_TARJETA;
      intentos_r    <= {CNT_W{1'b0}};
      digit_cnt_r   <= 3'd0;
      shift_r       <= 16'd0;
      digito_prev_r <= 1'b0;
      monto_prev_r  <= 1'b0;
      monto_r       <= 32'd0;
      tipo_r        <= 1'b0;
      balance_r     <= BALANCE_INIT;
      bal_act_r     <= 1'b0;
      entregar_r    <= 1'b0;
      pin_inc_r     <= 1'b0;
      fondos_r      <= 1'b0;
      adv_r         <= 1'b0;
      bloq_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      intentos_r    <= intentos_s;
      digit_cnt_r   <= digit_cnt_s;
      shift_r       <= shift_s;
      digito_prev_r <= DIGITO_STB;
      monto_prev_r  <= MONTO_STB;
      monto_r       <= monto_s;
      tipo_r        <= tipo_s;
      balance_r     <= balance_s;
      bal_act_r     <= bal_act_s;
      entregar_r    <= entregar_s;
      pin_inc_r     <= pin_inc_s;
      fondos_r      <= fondos_s;
      adv_r         <= adv_s;
      bloq_r        <= bloq_s;
    end
  end

  assign BALANCE              = balance_r;
  assign BALANCE_ACTUALIZADO  = bal_act_r;
  assign ENTREGAR_DINERO      = entregar_r;
  assign PIN_INCORRECTO       = pin_inc_r;
  assign ADVERTENCIA          = adv_r;
  assign BLOQUEO              = bloq_r;
  assign FONDOS_INSUFICIENTES = fondos_r;

endmodule

// File: tb/tb_cajero_atm_ctrl.sv
// Scoreboard bench for cajero_atm_ctrl: sessions push expected pulse
// events; a negedge monitor pops and compares whenever a pulse appears.
module tb_cajero_atm_ctrl;

  localparam int MAXI = 3;
  localparam logic [63:0] BAL0 = 64'd10000;
  localparam logic [15:0] GOOD = 16'h6969;
  localparam logic [15:0] BAD  = 16'h4444;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        TARGETA_RECIBIDA = 1'b0;
  logic [15:0] PIN = GOOD;
  logic [3:0]  DIGITO = 4'd0;
  logic        DIGITO_STB = 1'b0;
  logic        TIPO_TRANS = 1'b0;
  logic [31:0] MONTO = 32'd0;
  logic        MONTO_STB = 1'b0;
  logic [63:0] BALANCE;
  logic        BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO;
  logic        ADVERTENCIA, BLOQUEO, FONDOS_INSUFICIENTES;

  always #5 clock = ~clock;

  cajero_atm_ctrl dut (
    .clock(clock), .reset(reset), .TARGETA_RECIBIDA(TARGETA_RECIBIDA),
    .PIN(PIN), .DIGITO(DIGITO), .DIGITO_STB(DIGITO_STB),
    .TIPO_TRANS(TIPO_TRANS), .MONTO(MONTO), .MONTO_STB(MONTO_STB),
    .BALANCE(BALANCE), .BALANCE_ACTUALIZADO(BALANCE_ACTUALIZADO),
    .ENTREGAR_DINERO(ENTREGAR_DINERO), .PIN_INCORRECTO(PIN_INCORRECTO),
    .ADVERTENCIA(ADVERTENCIA), .BLOQUEO(BLOQUEO),
    .FONDOS_INSUFICIENTES(FONDOS_INSUFICIENTES)
  );

  // {bal_act, entregar, pin_inc, fondos, adv, bloq} and balance after the event
  typedef struct packed {
    logic [5:0]  flags;
    logic [63:0] bal;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          failures = 0;
  logic [63:0] m_bal = BAL0;
  int          m_int = 0;
  bit          m_locked = 1'b0;
  exp_t        mon_e;
  logic [5:0]  mon_got;

  function automatic exp_t mk_exp(input logic [3:0] pulses, input logic [63:0] bal);
    exp_t e;
    e.flags = {pulses, (m_int == MAXI - 1) && !m_locked, m_locked};
    e.bal   = bal;
    return e;
  endfunction

  // Monitor: every pulse must match the oldest expected event.
  always @(negedge clock) begin
    if (!reset && (BALANCE_ACTUALIZADO || ENTREGAR_DINERO || PIN_INCORRECTO || FONDOS_INSUFICIENTES)) begin
      mon_got = {BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO, FONDOS_INSUFICIENTES, ADVERTENCIA, BLOQUEO};
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse got=%b required=no pulse", mon_got);
      end else begin
        mon_e = sb.pop_front();
        if (mon_got !== mon_e.flags) begin
          failures++;
          $display("FAIL pulse_flags got=%b required=%b", mon_got, mon_e.flags);
        end
        checks++;
        if (BALANCE !== mon_e.bal) begin
          failures++;
          $display("FAIL event_balance got=%0d required=%0d", BALANCE, mon_e.bal);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) cyc(1);
  endtask

  task automatic do_reset();
    TARGETA_RECIBIDA = 1'b0; DIGITO_STB = 1'b0; MONTO_STB = 1'b0;
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    sb.delete();
    m_bal = BAL0; m_int = 0; m_locked = 1'b0;
    cyc(1);
  endtask

  task automatic strobe_digit(input logic [3:0] d);
    DIGITO = d; DIGITO_STB = 1'b1;
    cyc(2);
    DIGITO_STB = 1'b0;
    cyc(1);
  endtask

  // Card in, 4 digits, optional amount; expectations pushed before the strobes.
  task automatic run_session(input logic [15:0] digs, input bit with_amt,
                             input logic tipo, input logic [31:0] monto, input bit drop);
    bit pin_ok;
    pin_ok = 1'b0;
    TARGETA_RECIBIDA = 1'b1;
    cyc(2);
    if (!m_locked) begin
      if (digs != GOOD) begin
        m_int++;
        if (m_int == MAXI) m_locked = 1'b1;
        sb.push_back(mk_exp(4'b0010, m_bal));
      end else begin
        m_int  = 0;
        pin_ok = 1'b1;
      end
    end
    for (int i = 3; i >= 0; i--) strobe_digit(digs[i*4 +: 4]);
    cyc(3);
    if (with_amt) begin
      if (pin_ok) begin
        if (tipo == 1'b0) begin
          m_bal = m_bal + {32'd0, monto};
          sb.push_back(mk_exp(4'b1000, m_bal));
        end else if ({32'd0, monto} <= m_bal) begin
          m_bal = m_bal - {32'd0, monto};
          sb.push_back(mk_exp(4'b1100, m_bal));
        end else begin
          sb.push_back(mk_exp(4'b0001, m_bal));
        end
      end
      TIPO_TRANS = tipo; MONTO = monto; MONTO_STB = 1'b1;
      cyc(2);
      MONTO_STB = 1'b0;
      cyc(3);
    end
    if (drop) begin
      TARGETA_RECIBIDA = 1'b0;
      cyc(2);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (BALANCE !== 64'd10000) begin
      failures++; $display("FAIL reset_balance got=%0d required=10000", BALANCE);
    end
    checks++;
    if ({BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO, FONDOS_INSUFICIENTES, ADVERTENCIA, BLOQUEO} !== 6'b000000) begin
      failures++; $display("FAIL reset_outputs got=%b required=000000",
        {BALANCE_ACTUALIZADO, ENTREGAR_DINERO, PIN_INCORRECTO, FONDOS_INSUFICIENTES, ADVERTENCIA, BLOQUEO});
    end
  endtask

  task automatic test_transactions();
    run_session(GOOD, 1'b1, 1'b0, 32'd5000, 1'b1);   // deposit -> 15000
    run_session(GOOD, 1'b1, 1'b1, 32'd5000, 1'b1);   // withdraw -> 10000
    run_session(GOOD, 1'b1, 1'b1, 32'd20000, 1'b1);  // refused
    run_session(GOOD, 1'b1, 1'b1, 32'd10000, 1'b1);  // exact -> 0
    run_session(GOOD, 1'b1, 1'b1, 32'd1, 1'b1);      // refused at zero
    run_session(GOOD, 1'b1, 1'b0, 32'd10000, 1'b1);  // back to 10000
    wait_drain();
    checks++;
    if (sb.size() !== 0) begin
      failures++; $display("FAIL trans_drain got=%0d required=0", sb.size());
    end
    checks++;
    if (BALANCE !== 64'd10000) begin
      failures++; $display("FAIL trans_balance got=%0d required=10000", BALANCE);
    end
  endtask

  task automatic test_back_to_back();
    run_session(GOOD, 1'b1, 1'b0, 32'd123, 1'b0);
    run_session(GOOD, 1'b1, 1'b1, 32'd23, 1'b0);
    run_session(GOOD, 1'b1, 1'b0, 32'd7, 1'b1);
    wait_drain();
    checks++;
    if (sb.size() !== 0) begin
      failures++; $display("FAIL b2b_drain got=%0d required=0", sb.size());
    end
    checks++;
    if (BALANCE !== 64'd10107) begin
      failures++; $display("FAIL b2b_balance got=%0d required=10107", BALANCE);
    end
  endtask

  task automatic test_counter_clear();
    do_reset();
    run_session(BAD, 1'b0, 1'b0, 32'd0, 1'b1);
    run_session(GOOD, 1'b0, 1'b0, 32'd0, 1'b1);
    run_session(BAD, 1'b0, 1'b0, 32'd0, 1'b1);
    wait_drain();
    checks++;
    if (ADVERTENCIA !== 1'b0) begin
      failures++; $display("FAIL clear_adv_after_one got=%b required=0", ADVERTENCIA);
    end
    run_session(BAD, 1'b0, 1'b0, 32'd0, 1'b1);
    wait_drain();
    checks++;
    if ({ADVERTENCIA, BLOQUEO} !== 2'b10) begin
      failures++; $display("FAIL clear_adv_after_two got=%b required=10", {ADVERTENCIA, BLOQUEO});
    end
  endtask

  task automatic test_abort_card();
    do_reset();
    run_session(BAD, 1'b0, 1'b0, 32'd0, 1'b1);
    TARGETA_RECIBIDA = 1'b1;
    cyc(2);
    strobe_digit(4'd6);
    strobe_digit(4'd9);
    TARGETA_RECIBIDA = 1'b0;
    cyc(4);
    checks++;
    if (sb.size() !== 0 || ADVERTENCIA !== 1'b0) begin
      failures++; $display("FAIL abort_card_idle got=%0d/%b required=0/0", sb.size(), ADVERTENCIA);
    end
    run_session(BAD, 1'b0, 1'b0, 32'd0, 1'b1);       // counter kept: now 2
    run_session(GOOD, 1'b1, 1'b0, 32'd1, 1'b1);
    wait_drain();
    checks++;
    if ({ADVERTENCIA, BALANCE} !== {1'b0, 64'd10001}) begin
      failures++; $display("FAIL abort_card_after got=%b/%0d required=0/10001", ADVERTENCIA, BALANCE);
    end
  endtask

  task automatic test_abort_reset();
    do_reset();
    run_session(GOOD, 1'b1, 1'b0, 32'd50, 1'b0);
    TARGETA_RECIBIDA = 1'b1;
    cyc(2);
    strobe_digit(4'd6);
    strobe_digit(4'd9);
    do_reset();
    cyc(3);
    checks++;
    if (BALANCE !== 64'd10000) begin
      failures++; $display("FAIL abort_reset_balance got=%0d required=10000", BALANCE);
    end
    run_session(GOOD, 1'b1, 1'b1, 32'd400, 1'b1);
    wait_drain();
    checks++;
    if (BALANCE !== 64'd9600 || sb.size() !== 0) begin
      failures++; $display("FAIL abort_reset_after got=%0d/%0d required=9600/0", BALANCE, sb.size());
    end
  endtask

  task automatic test_lockout();
    do_reset();
    run_session(BAD, 1'b0, 1'b0, 32'd0, 1'b0);
    run_session(BAD, 1'b0, 1'b0, 32'd0, 1'b0);
    wait_drain();
    checks++;
    if ({ADVERTENCIA, BLOQUEO} !== 2'b10) begin
      failures++; $display("FAIL lock_warn got=%b required=10", {ADVERTENCIA, BLOQUEO});
    end
    run_session(BAD, 1'b0, 1'b0, 32'd0, 1'b0);
    wait_drain();
    checks++;
    if ({ADVERTENCIA, BLOQUEO} !== 2'b01) begin
      failures++; $display("FAIL lock_set got=%b required=01", {ADVERTENCIA, BLOQUEO});
    end
    run_session(GOOD, 1'b1, 1'b1, 32'd100, 1'b1);     // ignored while locked
    run_session(GOOD, 1'b1, 1'b0, 32'd100, 1'b0);
    checks++;
    if ({BLOQUEO, BALANCE} !== {1'b1, 64'd10000}) begin
      failures++; $display("FAIL lock_ignore got=%b/%0d required=1/10000", BLOQUEO, BALANCE);
    end
    do_reset();
    checks++;
    if ({ADVERTENCIA, BLOQUEO} !== 2'b00) begin
      failures++; $display("FAIL lock_reset got=%b required=00", {ADVERTENCIA, BLOQUEO});
    end
  endtask

  initial begin
    test_reset();
    test_transactions();
    test_back_to_back();
    test_counter_clear();
    test_abort_card();
    test_abort_reset();
    test_lockout();
    cyc(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1);
  end

endmodule
